ram_bank: RTL and testbench
===========================

# ram_bank

Parametrised single-port synchronous RAM bank with byte-lane write enables, a registered read port, and a multi-cycle clear engine that zeroes memory one word per cycle. It replaces the fixed 16-bit × 24-bit-address RAM as the main memory bank for the CPU datapath and the memory-mapped peripherals. The bidirectional data bus is split into separate write and read buses, and `busy` tells the bus master when the bank is clearing.

## Interface
Parameters:
- `DATA_W`, 16, word width in bits; must be a multiple of `BYTE_W`.
- `BYTE_W`, 8, width of one byte lane.
- `ADDR_W`, 24, address width; depth = 2**ADDR_W words.
- `CLEAR_ON_RESET`, 1, when 1 reset starts a full clear; when 0 reset leaves contents untouched.

Ports:
- `clk`  in  1  single clock; all logic updates on the rising edge.
- `r`  in  1  reset, synchronous, active-high.
- `we`  in  1  write request.
- `oe`  in  1  read request.
- `be`  in  DATA_W/BYTE_W  byte-lane enables for writes; bit i covers `wdata[i*BYTE_W +: BYTE_W]`.
- `addr`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `clr`  in  1  clear request; starts a full clear from IDLE.
- `rdata`  out  DATA_W  registered read data.
- `rvalid`  out  1  one-cycle pulse: `rdata` holds a new read result.
- `busy`  out  1  high while clearing; `we`, `oe` and `clr` are ignored while it is high.

## Operation
- FSM states:
  - IDLE: serves reads and writes.
  - CLEAR: writes 0 to `mem[ptr]` each cycle.
- Reset (`r`=1):
  - state ← CLEAR if `CLEAR_ON_RESET`, else IDLE.
  - ptr ← 0; `rdata` ← 0; `rvalid` ← 0.
  - While `r` stays high, ptr holds at 0 and no memory write occurs.
- CLEAR:
  - Each edge with `r`=0 writes `mem[ptr]`=0 and sets ptr ← ptr+1.
  - On the edge that writes ptr = 2**ADDR_W−1, state goes to IDLE; ptr wraps to 0.
- IDLE, `clr`=1: state goes to CLEAR with ptr=0. `clr` takes priority over `we`/`oe` in the same cycle; that cycle's request is dropped.
- IDLE, `we`=1: for each i with `be[i]`=1, lane i of `mem[addr]` ← lane i of `wdata`. Lanes with `be[i]`=0 keep their value. `be`=0 means no change.
- IDLE, `oe`=1: `rdata` ← `mem[addr]` and `rvalid` ← 1. Otherwise `rvalid` ← 0 and `rdata` holds its last value.
- `we` and `oe` in the same cycle: both execute. The read is read-first and returns the old word.
- Reset asserted mid-clear: the clear restarts from ptr 0. The partially cleared contents are not touched again until the restarted sweep reaches them.
- Requests dropped while `busy`=1 are not queued.

## Timing
- Output values during and right after reset:
  - `rdata`=0, `rvalid`=0.
  - `busy`=`CLEAR_ON_RESET`.
- Read latency is 1 cycle: `oe` sampled at edge N gives `rdata`/`rvalid` valid after edge N.
- Write takes effect at the sampling edge; a read at the next edge returns the new data.
- `busy` is a registered state decode, `busy` = (state == CLEAR):
  - After `r` falls, `busy` stays high for exactly 2**ADDR_W cycles.
  - After `clr` is accepted at edge N, `busy` rises after edge N and falls after edge N+2**ADDR_W.
- `rvalid` is never high while `busy` is high.

## Structure
- Package `ram_pkg`:
  - state enum {IDLE, CLEAR}.
  - Derived constant `LANES = DATA_W/BYTE_W`.
  - Elaboration check that `DATA_W % BYTE_W == 0`.
- Sub-module `ram_clear_seq` (FSM + ptr counter). Outputs: `busy`, `clr_we`, `clr_addr`.
- Top-level `ram_bank` contains:
  - the memory array;
  - the byte-lane write mux, which selects between the clear write and the user write;
  - the `rdata`/`rvalid` registers.

## Test plan
Bench uses `ADDR_W`=4, `DATA_W`=16, `BYTE_W`=8, `CLEAR_ON_RESET`=1 unless noted.
- Reset release: hold `r` 3 cycles, then release → `busy` high for exactly 16 cycles. Afterwards, reading all 16 addresses returns 0x0000 each, with `rvalid` pulsing 1 cycle after each `oe`.
- Byte lanes: write 0xABCD at addr 5 with `be`=11, then 0x1200 with `be`=10 → read addr 5 = 0x12CD.
- Read-during-write: `mem[3]`=0x1111; `we`+`oe` at addr 3 with `wdata`=0x2222 → `rdata`=0x1111 next cycle; a read the cycle after returns 0x2222.
- Requests during busy: assert `clr`, then 5 cycles later `we` addr 2 data 0xFFFF and `oe` → no `rvalid`. After `busy` falls, addr 2 reads 0x0000.
- Mid-clear reset: reset during a `clr` sweep at ptr=7 → `busy` remains high 16 cycles after `r` falls; all words read 0 afterwards.
- `CLEAR_ON_RESET`=0: write 0x5A5A at addr 9, pulse `r` → `busy` stays 0; addr 9 still reads 0x5A5A.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the ram_bank memory slice.
package ram_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_BYTE_W = 8;
    localparam int unsigned DEF_ADDR_W = 24;
    localparam int unsigned DEF_LANES  = DEF_DATA_W / DEF_BYTE_W;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int unsigned calc_lanes(input int unsigned data_w, input int unsigned byte_w);
        return data_w / byte_w;
    endfunction

    function automatic bit width_ok(input int unsigned data_w, input int unsigned byte_w);
        return (byte_w != 0) && ((data_w % byte_w) == 0);
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every word address once, issuing one zero-write per cycle.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              r,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;

    always_ff @(posedge clk) begin
        if (r) begin
            r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (clr) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            CLEAR: begin
                // ptr wraps to 0 on the final word, ready for the next sweep
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == {ADDR_W{1'b1}}) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = (r_state == CLEAR);
    // No memory write while reset is held
    assign clr_we   = (r_state == CLEAR) && !r;
    assign clr_addr = r_ptr;

endmodule

// File: rtl/ram_bank.sv
// Single-port RAM bank with byte-lane writes, registered read and a clear engine.
module ram_bank
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned BYTE_W         = DEF_BYTE_W,
    parameter int unsigned ADDR_W         = DEF_ADDR_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                       clk,
    input  logic                       r,
    input  logic                       we,
    input  logic                       oe,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       clr,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    output logic                       busy
);

    localparam int unsigned LANES = calc_lanes(DATA_W, BYTE_W);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    if (!width_ok(DATA_W, BYTE_W)) begin : g_bad_width
        $error("ram_bank: DATA_W must be a multiple of BYTE_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_user_ok;
    logic              w_user_we;
    logic              w_user_rd;

    ram_clear_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .r        (r),
        .clr      (clr),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    // clr wins over we/oe in the same cycle; everything is dropped while busy
    assign w_user_ok = !r && !w_busy && !clr;
    assign w_user_we = w_user_ok && we;
    assign w_user_rd = w_user_ok && oe;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_user_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    r_mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Read-first: a same-cycle write is not visible until the next read
    always_ff @(posedge clk) begin
        if (r) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_user_rd;
            if (w_user_rd) begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = w_busy;

endmodule

// File: tb/tb_ram_bank.sv
// Directed self-checking bench for ram_bank (clear-on-reset and no-clear variants).
module tb_ram_bank;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned LANES  = DATA_W / BYTE_W;

    logic              clk;
    logic              r;
    logic              we;
    logic              oe;
    logic [LANES-1:0]  be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              clr;
    logic [DATA_W-1:0] rdata,  rdata0;
    logic              rvalid, rvalid0;
    logic              busy,   busy0;

    int checks = 0;
    int passed = 0;
    int cnt;

    ram_bank #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .r(r), .we(we), .oe(oe), .be(be), .addr(addr), .wdata(wdata),
        .clr(clr), .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    ram_bank #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b0)) dut0 (
        .clk(clk), .r(r), .we(we), .oe(oe), .be(be), .addr(addr), .wdata(wdata),
        .clr(clr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [LANES-1:0] b);
        we = 1'b1; addr = a; wdata = d; be = b;
        step();
        we = 1'b0; be = '0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a);
        oe = 1'b1; addr = a;
        step();
        oe = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
    endtask

    initial begin
        r = 1'b1; we = 1'b0; oe = 1'b0; be = '0; addr = '0; wdata = '0; clr = 1'b0;

        // Reset release
        repeat (3) step();
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        check("rst_busy_nc", 32'(busy0), 32'h0);
        r = 1'b0;
        count_busy(cnt);
        check("rel_busy_len", 32'(cnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            rd(ADDR_W'(a));
            check("rel_rd_data", 32'(rdata), 32'h0);
            check("rel_rd_valid", 32'(rvalid), 32'h1);
        end
        step();
        check("rvalid_pulse", 32'(rvalid), 32'h0);

        // Byte lanes
        wr(4'd5, 16'hABCD, 2'b11);
        wr(4'd5, 16'h1200, 2'b10);
        rd(4'd5);
        check("lane_merge", 32'(rdata), 32'h12CD);
        wr(4'd5, 16'h9999, 2'b00);
        rd(4'd5);
        check("be_zero", 32'(rdata), 32'h12CD);

        // Read-during-write
        wr(4'd3, 16'h1111, 2'b11);
        we = 1'b1; oe = 1'b1; addr = 4'd3; wdata = 16'h2222; be = 2'b11;
        step();
        we = 1'b0; oe = 1'b0; be = '0;
        check("rdw_old", 32'(rdata), 32'h1111);
        check("rdw_valid", 32'(rvalid), 32'h1);
        rd(4'd3);
        check("rdw_new", 32'(rdata), 32'h2222);

        // Requests during busy (clear has already passed addr 2)
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_busy", 32'(busy), 32'h1);
        repeat (4) step();
        we = 1'b1; oe = 1'b1; addr = 4'd2; wdata = 16'hFFFF; be = 2'b11;
        step();
        we = 1'b0; oe = 1'b0; be = '0;
        check("busy_no_rvalid", 32'(rvalid), 32'h0);
        check("busy_still", 32'(busy), 32'h1);
        count_busy(cnt);
        check("clr_busy_end", 32'(busy), 32'h0);
        rd(4'd2);
        check("busy_wr_dropped", 32'(rdata), 32'h0);

        // Mid-clear reset
        wr(4'd10, 16'hBEEF, 2'b11);
        wr(4'd1, 16'h0101, 2'b11);
        wr(4'd14, 16'h7777, 2'b11);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (7) step();
        r = 1'b1;
        repeat (2) step();
        check("midrst_busy", 32'(busy), 32'h1);
        check("midrst_rvalid", 32'(rvalid), 32'h0);
        r = 1'b0;
        count_busy(cnt);
        check("midrst_busy_len", 32'(cnt), 32'd16);
        for (int a = 0; a < 16; a++) begin
            rd(ADDR_W'(a));
            check("midrst_rd", 32'(rdata), 32'h0);
        end

        // No clear on reset
        wr(4'd9, 16'h5A5A, 2'b11);
        r = 1'b1;
        step();
        check("nc_rst_busy", 32'(busy0), 32'h0);
        check("nc_rst_rdata", 32'(rdata0), 32'h0);
        r = 1'b0;
        step();
        check("nc_busy_after", 32'(busy0), 32'h0);
        rd(4'd9);
        check("nc_keep", 32'(rdata0), 32'h5A5A);
        check("nc_rvalid", 32'(rvalid0), 32'h1);
        check("c_no_rvalid", 32'(rvalid), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
